emu_dt_sched: RTL and testbench

EMU_DT_SCHED -- requirements
Module: emu_dt_sched

---
 rtl/emu_dt_sched.sv | 125 ++++++++++++
 tb/tb_emu_dt_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/emu_dt_sched.sv
// Emulation timestep scheduler: picks the smallest pending dt among
// enabled requesters, advances emulated time and guards against stalls.
module emu_dt_sched #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DT_WIDTH   = 27,
  parameter int unsigned TIME_WIDTH = 48,
  parameter int unsigned ZERO_LIMIT = 16
) (
  input  logic                      emu_clk,
  input  logic                      emu_rst,
  input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
  input  logic [N_REQ-1:0]          req_en,
  input  logic [DT_WIDTH-1:0]       ext_dt,
  input  logic                      run_en,
  input  logic                      step,
  input  logic                      clear_fault,
  output logic [DT_WIDTH-1:0]       emu_dt,
  output logic [N_REQ-1:0]          clk_en,
  output logic [TIME_WIDTH-1:0]     emu_time,
  output logic [31:0]               step_cnt,
  output logic                      fault,
  output logic                      time_sat
);

  localparam int unsigned ZW = $clog2(ZERO_LIMIT + 1);
  localparam int unsigned SW =
    ((TIME_WIDTH > DT_WIDTH) ? TIME_WIDTH : DT_WIDTH) + 1;
  localparam logic [ZW-1:0] ZLIM = ZW'(ZERO_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    FAULT
  } state_e;

  state_e                state_q;
  logic [TIME_WIDTH-1:0] time_q, time_d;
  logic [31:0]           cnt_q;
  logic [ZW-1:0]         zcnt_q, zcnt_d;
  logic                  sat_q;
  logic                  active;
  logic                  ovf;
  logic [SW-1:0]         sum;
  logic [DT_WIDTH-1:0]   min_dt;

  // Reset is folded in so the granted step is already zero in the reset cycle.
  assign active = ((state_q == RUN) || (state_q == STEP)) && !emu_rst;

  always_comb begin
    min_dt = ext_dt;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req_en[i] && (dt_req[i*DT_WIDTH +: DT_WIDTH] < min_dt)) begin
        min_dt = dt_req[i*DT_WIDTH +: DT_WIDTH];
      end
    end
  end

  always_comb begin
    emu_dt = active ? min_dt : '0;
    clk_en = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      clk_en[i] = active && req_en[i] &&
                  (dt_req[i*DT_WIDTH +: DT_WIDTH] == min_dt);
    end
  end

  always_comb begin
    sum    = SW'(time_q) + SW'(emu_dt);
    ovf    = (sum[SW-1:TIME_WIDTH] != '0);
    time_d = ovf ? '1 : sum[TIME_WIDTH-1:0];
    zcnt_d = zcnt_q;
    if (active) begin
      if (emu_dt != '0) begin
        zcnt_d = '0;
      end else if (zcnt_q != ZLIM) begin
        zcnt_d = zcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q <= IDLE;
      time_q  <= '0;
      cnt_q   <= '0;
      zcnt_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      if (active) begin
        time_q <= time_d;
        cnt_q  <= cnt_q + 32'd1;
        zcnt_q <= zcnt_d;
        if (ovf) sat_q <= 1'b1;
      end
      // Stall detection outranks every other transition.
      if ((state_q != FAULT) && (zcnt_d == ZLIM)) begin
        state_q <= FAULT;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (run_en)    state_q <= RUN;
            else if (step) state_q <= STEP;
          end
          RUN: begin
            if (!run_en) state_q <= IDLE;
          end
          STEP: state_q <= IDLE;
          FAULT: begin
            if (clear_fault) begin
              state_q <= IDLE;
              zcnt_q  <= '0;
            end
          end
        endcase
      end
    end
  end

  assign emu_time = time_q;
  assign step_cnt = cnt_q;
  assign fault    = (state_q == FAULT);
  assign time_sat = sat_q;

endmodule

// File: tb/tb_emu_dt_sched.sv
// Bench for emu_dt_sched: directed scenarios then random traffic,
// all checked against a cycle-level reference model.
module tb_emu_dt_sched;

  localparam int N  = 4;
  localparam int DW = 27;
  localparam int TW = 48;
  localparam int ZL = 16;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STEP  = 2;
  localparam int M_FAULT = 3;

  logic          emu_clk = 1'b0;
  logic          emu_rst;
  logic [N*DW-1:0] dt_req;
  logic [N-1:0]  req_en;
  logic [DW-1:0] ext_dt;
  logic          run_en, step, clear_fault;
  logic [DW-1:0] emu_dt;
  logic [N-1:0]  clk_en;
  logic [TW-1:0] emu_time;
  logic [31:0]   step_cnt;
  logic          fault, time_sat;

  logic [DW-1:0] s_dt;
  logic [N-1:0]  s_ce;
  logic [7:0]    s_time;
  logic [31:0]   s_cnt;
  logic          s_fault, s_sat;

  int vectors = 0;
  int miscompares = 0;

  int          mmode;
  longint      mtime;
  int          mt8;
  int unsigned mcnt;
  int          mz;
  bit          msat, msat8;

  always #5 emu_clk = ~emu_clk;

  emu_dt_sched #(
    .N_REQ(N), .DT_WIDTH(DW), .TIME_WIDTH(TW), .ZERO_LIMIT(ZL)
  ) dut (
    .emu_clk(emu_clk), .emu_rst(emu_rst), .dt_req(dt_req),
    .req_en(req_en), .ext_dt(ext_dt), .run_en(run_en), .step(step),
    .clear_fault(clear_fault), .emu_dt(emu_dt), .clk_en(clk_en),
    .emu_time(emu_time), .step_cnt(step_cnt), .fault(fault),
    .time_sat(time_sat)
  );

  emu_dt_sched #(
    .N_REQ(N), .DT_WIDTH(DW), .TIME_WIDTH(8), .ZERO_LIMIT(ZL)
  ) dut8 (
    .emu_clk(emu_clk), .emu_rst(emu_rst), .dt_req(dt_req),
    .req_en(req_en), .ext_dt(ext_dt), .run_en(run_en), .step(step),
    .clear_fault(clear_fault), .emu_dt(s_dt), .clk_en(s_ce),
    .emu_time(s_time), .step_cnt(s_cnt), .fault(s_fault),
    .time_sat(s_sat)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setd(input int i, input int v);
    dt_req[i*DW +: DW] = DW'(v);
  endtask

  function automatic longint ref_min();
    longint m = longint'(ext_dt);
    for (int i = 0; i < N; i++) begin
      if (req_en[i] && longint'(dt_req[i*DW +: DW]) < m)
        m = longint'(dt_req[i*DW +: DW]);
    end
    return m;
  endfunction

  task automatic model_edge(input longint d);
    bit act;
    if (emu_rst) begin
      mmode = M_IDLE; mtime = 0; mt8 = 0; mcnt = 0; mz = 0;
      msat = 0; msat8 = 0;
      return;
    end
    act = (mmode == M_RUN || mmode == M_STEP);
    if (act) begin
      mtime = mtime + d;
      if (mtime > (longint'(1) << TW) - 1) begin
        mtime = (longint'(1) << TW) - 1; msat = 1;
      end
      if (longint'(mt8) + d > 255) begin
        mt8 = 255; msat8 = 1;
      end else begin
        mt8 = mt8 + int'(d);
      end
      mcnt = mcnt + 1;
      mz = (d == 0) ? ((mz + 1 > ZL) ? ZL : mz + 1) : 0;
    end
    if (mmode != M_FAULT && mz >= ZL) begin
      mmode = M_FAULT;
    end else begin
      case (mmode)
        M_IDLE:  mmode = run_en ? M_RUN : (step ? M_STEP : M_IDLE);
        M_RUN:   mmode = run_en ? M_RUN : M_IDLE;
        M_STEP:  mmode = M_IDLE;
        default: if (clear_fault) begin mmode = M_IDLE; mz = 0; end
      endcase
    end
  endtask

  // One clock: check combinational grant, advance, check registered state.
  task automatic cyc();
    bit            act;
    longint        d;
    logic [N-1:0]  ce;
    #1;
    act = (mmode == M_RUN || mmode == M_STEP) && !emu_rst;
    d = act ? ref_min() : 0;
    ce = '0;
    for (int i = 0; i < N; i++)
      ce[i] = act && req_en[i] && (longint'(dt_req[i*DW +: DW]) == d);
    chk("emu_dt", 64'(emu_dt), 64'(d));
    chk("clk_en", 64'(clk_en), 64'(ce));
    @(posedge emu_clk);
    model_edge(d);
    #1;
    chk("emu_time", 64'(emu_time), 64'(mtime));
    chk("step_cnt", 64'(step_cnt), 64'(mcnt));
    chk("fault", 64'(fault), 64'(mmode == M_FAULT));
    chk("time_sat", 64'(time_sat), 64'(msat));
    chk("time8", 64'(s_time), 64'(mt8));
    chk("sat8", 64'(s_sat), 64'(msat8));
  endtask

  task automatic do_reset();
    emu_rst = 1'b1; cyc();
    emu_rst = 1'b0;
  endtask

  initial begin
    mmode = M_IDLE; mtime = 0; mt8 = 0; mcnt = 0; mz = 0;
    msat = 0; msat8 = 0;
    emu_rst = 1'b1; dt_req = '0; req_en = '0; ext_dt = '0;
    run_en = 1'b0; step = 1'b0; clear_fault = 1'b0;
    @(negedge emu_clk);
    cyc(); cyc();
    emu_rst = 1'b0;
    cyc();

    // arbitration with a tie on lanes 1 and 2
    setd(3, 40); setd(2, 25); setd(1, 25); setd(0, 90);
    req_en = 4'b1111; ext_dt = 100; run_en = 1'b1;
    cyc();
    chk("arb_dt", 64'(emu_dt), 64'd25);
    chk("arb_ce", 64'(clk_en), 64'b0110);
    for (int k = 0; k < 4; k++) cyc();
    chk("arb_time", 64'(emu_time), 64'd100);

    // ext_dt bound and masking
    req_en = 4'b0001; setd(0, 300);
    #1;
    chk("bound_dt", 64'(emu_dt), 64'd100);
    chk("bound_ce", 64'(clk_en), 64'd0);
    cyc();
    req_en = 4'b0000;
    cyc();
    run_en = 1'b0;
    cyc(); cyc();

    // single step
    do_reset();
    req_en = 4'b0001; setd(0, 7); ext_dt = 50;
    step = 1'b1; cyc();
    step = 1'b0;
    chk("step_dt", 64'(emu_dt), 64'd7);
    chk("step_ce", 64'(clk_en), 64'b0001);
    cyc();
    chk("step_cnt1", 64'(step_cnt), 64'd1);
    chk("step_time", 64'(emu_time), 64'd7);
    chk("step_idle_dt", 64'(emu_dt), 64'd0);
    cyc();

    // zero-step fault and recovery
    setd(0, 0); run_en = 1'b1;
    cyc();
    for (int k = 0; k < ZL; k++) cyc();
    chk("zero_fault", 64'(fault), 64'd1);
    chk("zero_dt", 64'(emu_dt), 64'd0);
    cyc(); cyc();
    clear_fault = 1'b1; run_en = 1'b0; cyc();
    clear_fault = 1'b0;
    chk("clear_fault", 64'(fault), 64'd0);
    run_en = 1'b1;
    for (int k = 0; k < ZL + 2; k++) cyc();
    clear_fault = 1'b1; run_en = 1'b0; cyc();
    clear_fault = 1'b0;

    // saturation on the 8-bit instance
    do_reset();
    req_en = '0; ext_dt = 25; run_en = 1'b1;
    cyc();
    for (int k = 0; k < 10; k++) cyc();
    chk("sat_pre", 64'(s_time), 64'd250);
    ext_dt = 10; cyc();
    chk("sat_time", 64'(s_time), 64'd255);
    chk("sat_flag", 64'(s_sat), 64'd1);
    ext_dt = 3; cyc(); cyc();
    chk("sat_sticky", 64'(s_sat), 64'd1);

    // reset in the middle of a run
    do_reset();
    ext_dt = 3; run_en = 1'b1;
    cyc();
    for (int k = 0; k < 5; k++) cyc();
    chk("mid_cnt5", 64'(step_cnt), 64'd5);
    emu_rst = 1'b1; cyc();
    emu_rst = 1'b0;
    chk("mid_cnt", 64'(step_cnt), 64'd0);
    chk("mid_time", 64'(emu_time), 64'd0);
    chk("mid_dt", 64'(emu_dt), 64'd0);
    cyc();

    // random traffic
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++)
        setd(i, ($urandom_range(0, 9) == 0) ?
                int'($urandom_range(0, (1 << DW) - 1)) :
                int'($urandom_range(0, 12)));
      req_en = N'($urandom);
      ext_dt = ($urandom_range(0, 5) == 0) ?
               DW'($urandom) : DW'($urandom_range(0, 15));
      run_en = ($urandom_range(0, 3) != 0);
      step = $urandom_range(0, 1) == 1;
      clear_fault = ($urandom_range(0, 9) == 0);
      emu_rst = ($urandom_range(0, 49) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
